// File: rtl/pong_match_ctl.sv
// Pong match sequencer: derives a frame tick from vsync, runs the serve and
// game-over countdowns, keeps both scores and declares the winner.
// Optional feature macro: PONG_PAUSE_EN adds a pause input and PAUSED state.
module pong_match_ctl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               start,
  input  logic               abort,
  input  logic               miss_left,
  input  logic               miss_right,
`ifdef PONG_PAUSE_EN
  input  logic               pause,
`endif
  output logic               frame_tick,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic [1:0]         winner
);

  typedef enum logic [2:0] {
    StIdle,
    StServe,
    StPlay,
`ifdef PONG_PAUSE_EN
    StPaused,
`endif
    StOver
  } state_e;

  localparam logic [SCORE_W-1:0] WinScore    = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   ServeFrames = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   OverFrames  = CNT_W'(OVER_FRAMES);
  localparam logic [CNT_W-1:0]   CntOne      = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vsync_q, vsync_d;
  logic               frame_tick_q, frame_tick_d;
  logic               ball_run_q, ball_run_d;
  logic               ball_reset_q, ball_reset_d;
  logic               serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               game_over_q, game_over_d;
  logic [1:0]         winner_q, winner_d;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

`ifdef PONG_PAUSE_EN
  logic pause_q, pause_d;
  logic pause_rise;
  assign pause_rise = pause & ~pause_q;
`endif

  // Saturating increments so a score can never pass the winning value.
  always_comb begin
    score_l_inc = (score_l_q >= WinScore) ? score_l_q : score_l_q + SCORE_W'(1);
    score_r_inc = (score_r_q >= WinScore) ? score_r_q : score_r_q + SCORE_W'(1);
  end

  // Next-state, countdown, score and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vsync_d      = vsync_in;
    frame_tick_d = vsync_in & ~vsync_q;
    ball_reset_d = 1'b0;
    serve_dir_d  = serve_dir_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    winner_d     = winner_q;
`ifdef PONG_PAUSE_EN
    pause_d      = pause;
`endif

    unique case (state_q)
      StIdle: begin
        // abort outranks start while idle
        if (!abort && start) begin
          state_d      = StServe;
          score_l_d    = '0;
          score_r_d    = '0;
          winner_d     = 2'b00;
          serve_dir_d  = 1'b1;
          cnt_d        = ServeFrames;
          ball_reset_d = 1'b1;
        end
      end

      StServe: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (frame_tick_q) begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q <= CntOne) begin
            state_d = StPlay;
            cnt_d   = '0;
          end
        end
      end

      StPlay: begin
        // Frame ticks are ignored here; only misses drive transitions.
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
`ifdef PONG_PAUSE_EN
        end else if (pause_rise) begin
          state_d = StPaused;
`endif
        end else if (miss_left && miss_right) begin
          // Simultaneous misses: replay the point without scoring.
          state_d      = StServe;
          cnt_d        = ServeFrames;
          ball_reset_d = 1'b1;
        end else if (miss_left) begin
          score_r_d   = score_r_inc;
          serve_dir_d = 1'b0;
          if (score_r_inc == WinScore) begin
            state_d  = StOver;
            winner_d = 2'b10;
            cnt_d    = OverFrames;
          end else begin
            state_d      = StServe;
            cnt_d        = ServeFrames;
            ball_reset_d = 1'b1;
          end
        end else if (miss_right) begin
          score_l_d   = score_l_inc;
          serve_dir_d = 1'b1;
          if (score_l_inc == WinScore) begin
            state_d  = StOver;
            winner_d = 2'b01;
            cnt_d    = OverFrames;
          end else begin
            state_d      = StServe;
            cnt_d        = ServeFrames;
            ball_reset_d = 1'b1;
          end
        end
      end

`ifdef PONG_PAUSE_EN
      StPaused: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (pause_rise) begin
          state_d = StPlay;
        end
      end
`endif

      StOver: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (frame_tick_q) begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q <= CntOne) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Level outputs follow the state being entered so they are registered.
    ball_run_d  = (state_d == StPlay);
    game_over_d = (state_d == StOver);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      vsync_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      serve_dir_q  <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
`ifdef PONG_PAUSE_EN
      pause_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
      ball_run_q   <= ball_run_d;
      ball_reset_q <= ball_reset_d;
      serve_dir_q  <= serve_dir_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
`ifdef PONG_PAUSE_EN
      pause_q      <= pause_d;
`endif
    end
  end

  assign frame_tick = frame_tick_q;
  assign ball_run   = ball_run_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctl.sv
// Directed bench for pong_match_ctl with short serve/over countdowns.
module tb_pong_match_ctl;

  localparam int unsigned WinScore    = 3;
  localparam int unsigned ScoreW      = 4;
  localparam int unsigned ServeFrames = 3;
  localparam int unsigned OverFrames  = 2;
  localparam int unsigned CntW        = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              vsync_in;
  logic              start;
  logic              abort;
  logic              miss_left;
  logic              miss_right;
`ifdef PONG_PAUSE_EN
  logic              pause;
`endif
  logic              frame_tick;
  logic              ball_run;
  logic              ball_reset;
  logic              serve_dir;
  logic [ScoreW-1:0] score_l;
  logic [ScoreW-1:0] score_r;
  logic              game_over;
  logic [1:0]        winner;

  int checks = 0;
  int errors = 0;

  pong_match_ctl #(
    .WIN_SCORE   (WinScore),
    .SCORE_W     (ScoreW),
    .SERVE_FRAMES(ServeFrames),
    .OVER_FRAMES (OverFrames),
    .CNT_W       (CntW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .vsync_in  (vsync_in),
    .start     (start),
    .abort     (abort),
    .miss_left (miss_left),
    .miss_right(miss_right),
`ifdef PONG_PAUSE_EN
    .pause     (pause),
`endif
    .frame_tick(frame_tick),
    .ball_run  (ball_run),
    .ball_reset(ball_reset),
    .serve_dir (serve_dir),
    .score_l   (score_l),
    .score_r   (score_r),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // One vsync rising edge; returns once the FSM has consumed the tick.
  task automatic frame();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic serve_frames();
    frame();
    frame();
    frame();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    miss_left  = l;
    miss_right = r;
    step();
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    vsync_in   = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
`ifdef PONG_PAUSE_EN
    pause      = 1'b0;
`endif
    step();
    step();
    check_eq("rst_frame_tick", 32'(frame_tick), 0);
    check_eq("rst_ball_run", 32'(ball_run), 0);
    check_eq("rst_ball_reset", 32'(ball_reset), 0);
    check_eq("rst_serve_dir", 32'(serve_dir), 0);
    check_eq("rst_score_l", 32'(score_l), 0);
    check_eq("rst_score_r", 32'(score_r), 0);
    check_eq("rst_game_over", 32'(game_over), 0);
    check_eq("rst_winner", 32'(winner), 0);
    rst = 1'b0;
    step();

    // 1: three vsync edges, each held two cycles, give three one-cycle ticks
    for (int i = 0; i < 3; i++) begin
      vsync_in = 1'b1;
      step();
      check_eq("t1_tick_high", 32'(frame_tick), 1);
      step();
      check_eq("t1_tick_width", 32'(frame_tick), 0);
      vsync_in = 1'b0;
      step();
      check_eq("t1_tick_low", 32'(frame_tick), 0);
      check_eq("t1_ball_run", 32'(ball_run), 0);
      check_eq("t1_game_over", 32'(game_over), 0);
      check_eq("t1_ball_reset", 32'(ball_reset), 0);
    end

    // 2: start, serve countdown of three ticks
    pulse_start();
    check_eq("t2_ball_reset", 32'(ball_reset), 1);
    check_eq("t2_serve_dir", 32'(serve_dir), 1);
    check_eq("t2_ball_run0", 32'(ball_run), 0);
    step();
    check_eq("t2_ball_reset_end", 32'(ball_reset), 0);
    frame();
    frame();
    check_eq("t2_ball_run_2ticks", 32'(ball_run), 0);
    frame();
    check_eq("t2_ball_run_3ticks", 32'(ball_run), 1);

    // 3: left player wins 3-0, then game-over countdown of two ticks
    for (int k = 1; k < 3; k++) begin
      pulse_miss(1'b0, 1'b1);
      check_eq("t3_score_l", 32'(score_l), 32'(k));
      check_eq("t3_ball_run_off", 32'(ball_run), 0);
      check_eq("t3_ball_reset", 32'(ball_reset), 1);
      serve_frames();
      check_eq("t3_ball_run_on", 32'(ball_run), 1);
    end
    pulse_miss(1'b0, 1'b1);
    check_eq("t3_score_win", 32'(score_l), 3);
    check_eq("t3_game_over", 32'(game_over), 1);
    check_eq("t3_winner", 32'(winner), 1);
    check_eq("t3_ball_run_over", 32'(ball_run), 0);
    check_eq("t3_no_reset_over", 32'(ball_reset), 0);
    frame();
    check_eq("t3_over_1tick", 32'(game_over), 1);
    frame();
    check_eq("t3_over_done", 32'(game_over), 0);
    check_eq("t3_score_held", 32'(score_l), 3);
    check_eq("t3_winner_held", 32'(winner), 1);
    check_eq("t3_idle_ball_run", 32'(ball_run), 0);

    // 4: restart clears; miss outside PLAY ignored; double miss replays
    pulse_start();
    check_eq("t4_score_l_clr", 32'(score_l), 0);
    check_eq("t4_winner_clr", 32'(winner), 0);
    check_eq("t4_ball_reset", 32'(ball_reset), 1);
    pulse_miss(1'b0, 1'b1);
    check_eq("t4_serve_miss_ign", 32'(score_l), 0);
    serve_frames();
    check_eq("t4_play", 32'(ball_run), 1);
    pulse_miss(1'b1, 1'b0);
    check_eq("t4_score_r", 32'(score_r), 1);
    check_eq("t4_serve_dir_left", 32'(serve_dir), 0);
    serve_frames();
    pulse_miss(1'b1, 1'b1);
    check_eq("t4_dbl_score_l", 32'(score_l), 0);
    check_eq("t4_dbl_score_r", 32'(score_r), 1);
    check_eq("t4_dbl_serve_dir", 32'(serve_dir), 0);
    check_eq("t4_dbl_ball_reset", 32'(ball_reset), 1);
    check_eq("t4_dbl_ball_run", 32'(ball_run), 0);
    frame();
    frame();
    check_eq("t4_dbl_serving", 32'(ball_run), 0);
    frame();
    check_eq("t4_dbl_replay", 32'(ball_run), 1);

    // 5: reach 2-1 in SERVE, abort with start, then restart
    pulse_miss(1'b0, 1'b1);
    serve_frames();
    pulse_miss(1'b0, 1'b1);
    check_eq("t5_score_l_2", 32'(score_l), 2);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_eq("t5_abort_ball_run", 32'(ball_run), 0);
    check_eq("t5_abort_score_l", 32'(score_l), 2);
    check_eq("t5_abort_score_r", 32'(score_r), 1);
    check_eq("t5_abort_no_reset", 32'(ball_reset), 0);
    serve_frames();
    check_eq("t5_idle_no_play", 32'(ball_run), 0);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_eq("t5_idle_abort_wins", 32'(ball_reset), 0);
    check_eq("t5_idle_abort_score", 32'(score_l), 2);
    pulse_start();
    check_eq("t5_restart_l", 32'(score_l), 0);
    check_eq("t5_restart_r", 32'(score_r), 0);
    check_eq("t5_restart_reset", 32'(ball_reset), 1);
    serve_frames();
    abort      = 1'b1;
    miss_right = 1'b1;
    step();
    abort      = 1'b0;
    miss_right = 1'b0;
    check_eq("t5_play_abort_run", 32'(ball_run), 0);
    check_eq("t5_play_abort_miss", 32'(score_l), 0);

`ifdef PONG_PAUSE_EN
    // 6: pause and resume in PLAY, abort from PAUSED
    pulse_start();
    serve_frames();
    check_eq("t6_play", 32'(ball_run), 1);
    pause = 1'b1;
    step();
    check_eq("t6_paused", 32'(ball_run), 0);
    pulse_miss(1'b1, 1'b0);
    check_eq("t6_miss_ignored", 32'(score_r), 0);
    pause = 1'b0;
    step();
    step();
    check_eq("t6_still_paused", 32'(ball_run), 0);
    pause = 1'b1;
    step();
    check_eq("t6_resumed", 32'(ball_run), 1);
    pause = 1'b0;
    step();
    pause = 1'b1;
    step();
    check_eq("t6_paused_again", 32'(ball_run), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    pause = 1'b0;
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check_eq("t6_idle_pause_ign", 32'(ball_run), 0);
    serve_frames();
    check_eq("t6_idle_after_abort", 32'(ball_run), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
